// File: rtl/sorted_rle_encoder_pkg.sv
// Shared constants, state encoding and small helpers for the sorted-array
// run-length encoder that follows the heap sorter.
package sorted_rle_encoder_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int CW    = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        EMIT = 3'd3,
        LAST = 3'd4,
        DONE = 3'd5
    } state_t;

    function automatic logic is_final(input logic [AW-1:0] idx);
        return (idx == AW'(DEPTH - 1));
    endfunction

endpackage

// File: rtl/sorted_rle_encoder_if.sv
// Valid/ready stream carrying (value, count, last) run-length pairs.
interface sorted_rle_encoder_if;
    import sorted_rle_encoder_pkg::*;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_value;
    logic [CW-1:0] out_count;
    logic          out_last;

    modport master (
        output out_valid,
        output out_value,
        output out_count,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        input  out_count,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/sorted_rle_encoder.sv
// Scans the sorted IRAM contents in address order and streams run-length pairs;
// one read per element, with a one-cycle read latency on ram_q.
module sorted_rle_encoder
    import sorted_rle_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ram_rd,
    output logic [AW-1:0]         ram_a,
    input  logic [DW-1:0]         ram_q,
    sorted_rle_encoder_if.master  out_if,
    output logic                  busy,
    output logic                  done
);

    state_t        state_r;
    logic [AW-1:0] idx_r;
    logic [DW-1:0] cur_val_r;
    logic [CW-1:0] cur_cnt_r;
    logic [DW-1:0] nxt_val_r;
    logic          ram_rd_r;
    logic [AW-1:0] ram_a_r;
    logic          out_valid_r;
    logic [DW-1:0] out_value_r;
    logic [CW-1:0] out_count_r;
    logic          out_last_r;
    logic          busy_r;
    logic          done_r;

    logic          run_match_s;
    logic [DW-1:0] run_val_s;
    logic [CW-1:0] run_cnt_s;

    // Element 0 always opens a run; later elements extend it when equal.
    always_comb begin
        run_match_s = 1'b0;
        run_val_s   = cur_val_r;
        run_cnt_s   = cur_cnt_r;
        if (idx_r == AW'(0)) begin
            run_match_s = 1'b1;
            run_val_s   = ram_q;
            run_cnt_s   = CW'(1);
        end else begin
            run_match_s = (ram_q == cur_val_r);
            run_val_s   = cur_val_r;
            run_cnt_s   = cur_cnt_r + CW'(1);
        end
    end

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= AW'(0);
            cur_val_r   <= DW'(0);
            cur_cnt_r   <= CW'(0);
            nxt_val_r   <= DW'(0);
            ram_rd_r    <= 1'b0;
            ram_a_r     <= AW'(0);
            out_valid_r <= 1'b0;
            out_value_r <= DW'(0);
            out_count_r <= CW'(0);
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        idx_r    <= AW'(0);
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                        ram_rd_r <= 1'b1;
                        ram_a_r  <= AW'(0);
                        state_r  <= ADDR;
                    end
                end
                ADDR: begin
                    ram_rd_r <= 1'b0;
                    state_r  <= DATA;
                end
                DATA: begin
                    if (run_match_s) begin
                        cur_val_r <= run_val_s;
                        cur_cnt_r <= run_cnt_s;
                        if (is_final(idx_r)) begin
                            out_value_r <= run_val_s;
                            out_count_r <= run_cnt_s;
                            out_last_r  <= 1'b1;
                            out_valid_r <= 1'b1;
                            state_r     <= LAST;
                        end else begin
                            idx_r    <= idx_r + AW'(1);
                            ram_rd_r <= 1'b1;
                            ram_a_r  <= idx_r + AW'(1);
                            state_r  <= ADDR;
                        end
                    end else begin
                        out_value_r <= cur_val_r;
                        out_count_r <= cur_cnt_r;
                        out_last_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        nxt_val_r   <= ram_q;
                        state_r     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_if.out_ready) begin
                        cur_val_r <= nxt_val_r;
                        cur_cnt_r <= CW'(1);
                        if (is_final(idx_r)) begin
                            // The value that broke the run is also the last element.
                            out_value_r <= nxt_val_r;
                            out_count_r <= CW'(1);
                            out_last_r  <= 1'b1;
                            state_r     <= LAST;
                        end else begin
                            out_valid_r <= 1'b0;
                            idx_r       <= idx_r + AW'(1);
                            ram_rd_r    <= 1'b1;
                            ram_a_r     <= idx_r + AW'(1);
                            state_r     <= ADDR;
                        end
                    end
                end
                LAST: begin
                    if (out_if.out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ram_rd           = ram_rd_r;
    assign ram_a            = ram_a_r;
    assign out_if.out_valid = out_valid_r;
    assign out_if.out_value = out_value_r;
    assign out_if.out_count = out_count_r;
    assign out_if.out_last  = out_last_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_sorted_rle_encoder.sv
// Bench for sorted_rle_encoder: directed scenarios plus random IRAM contents
// with random backpressure, checked against a run-length model of the array.
module tb_sorted_rle_encoder;
    import sorted_rle_encoder_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ram_rd;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_q;
    logic          busy;
    logic          done;

    sorted_rle_encoder_if bus();

    sorted_rle_encoder dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ram_rd (ram_rd),
        .ram_a  (ram_a),
        .ram_q  (ram_q),
        .out_if (bus.master),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]     mem [DEPTH];
    logic [CW+DW:0]    got [$];
    logic [CW+DW:0]    exp_q [$];
    int                compared   = 0;
    int                mismatched = 0;
    int                stall_cycles;

    always @(posedge clk) begin
        if (ram_rd) ram_q <= mem[ram_a];
    end

    always @(posedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready)
            got.push_back({bus.out_last, bus.out_count, bus.out_value});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: one pair per maximal run of equal neighbours, last flag on the final run.
    function automatic void build_exp();
        int run;
        exp_q.delete();
        run = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == DEPTH || mem[i] != mem[i-1]) begin
                exp_q.push_back({(i == DEPTH), CW'(run), mem[i-1]});
                run = 1;
            end else begin
                run++;
            end
        end
    endfunction

    task automatic compare_pairs(input string tag);
        int sum;
        build_exp();
        check({tag, "_npairs"}, got.size(), exp_q.size());
        sum = 0;
        for (int i = 0; i < got.size(); i++) begin
            sum += int'(got[i][CW+DW-1:DW]);
            if (i < exp_q.size())
                check($sformatf("%s_pair%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        end
        check({tag, "_sum"}, sum, DEPTH);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // mode: 0 ready=1, 1 random ready, 2 stall on (3,3), 3 start pulses while busy, 4 reset in EMIT
    task automatic run_scan(input int mode, output int first_valid, output int done_rises);
        int          n;
        int          tail;
        bit          finished;
        logic        prev_done;
        logic [CW+DW:0] held;
        got.delete();
        first_valid  = -1;
        done_rises   = 0;
        stall_cycles = 0;
        prev_done    = 1'b0;
        held         = '0;
        @(posedge clk); #1;
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        n        = 1;
        tail     = -1;
        finished = 1'b0;
        while (!finished && n < 400) begin
            start = 1'b0;
            if (bus.out_valid && first_valid < 0) first_valid = n;
            if (done && !prev_done) begin
                done_rises++;
                if (tail < 0) tail = 6;
            end
            prev_done = done;
            case (mode)
                1: bus.out_ready = ($urandom_range(0, 1) == 1);
                2: begin
                    if (bus.out_valid && bus.out_value == 8'h03 && bus.out_count == 5'd3
                        && stall_cycles < 5) begin
                        if (stall_cycles == 0)
                            held = {bus.out_last, bus.out_count, bus.out_value};
                        else
                            check("t4_hold", 32'({bus.out_last, bus.out_count, bus.out_value}), 32'(held));
                        check("t4_no_rd", ram_rd, 1'b0);
                        bus.out_ready = 1'b0;
                        stall_cycles++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                3: begin
                    bus.out_ready = 1'b1;
                    if (n == 7 || n == 20 || n == first_valid) start = 1'b1;
                end
                4: begin
                    if (bus.out_valid && !bus.out_last) begin
                        reset = 1'b1;
                        #1;
                        check("t6_reset_outs", 32'({ram_rd, ram_a, bus.out_valid, bus.out_value,
                              bus.out_count, bus.out_last, busy, done}), 32'd0);
                        #1;
                        reset    = 1'b0;
                        finished = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
            if (tail == 0) finished = 1'b1;
            else if (tail > 0) tail--;
            if (!finished) begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!finished) check("scan_timeout", 32'd0, 32'd1);
        start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int fv;
        int dr;
        logic [DW-1:0] t3 [DEPTH];
        t3 = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd7, 8'd7,
               8'd7, 8'd7, 8'd8, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

        @(posedge clk); @(posedge clk); #1;
        check("reset_outs", 32'({ram_rd, ram_a, bus.out_valid, bus.out_value,
              bus.out_count, bus.out_last, busy, done}), 32'd0);
        reset = 1'b0;

        // T1: all equal
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h5A;
        run_scan(0, fv, dr);
        check("t1_latency", fv, 2 * DEPTH + 1);
        compare_pairs("t1");

        // T2: all distinct
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        run_scan(0, fv, dr);
        compare_pairs("t2");

        // T3: mixed runs
        mem = t3;
        run_scan(0, fv, dr);
        compare_pairs("t3");

        // T4: backpressure on the (3,3) pair
        run_scan(2, fv, dr);
        check("t4_stalls", stall_cycles, 5);
        compare_pairs("t4");

        // T5: start pulses while busy are ignored
        run_scan(3, fv, dr);
        check("t5_done_once", dr, 1);
        compare_pairs("t5");

        // T6: reset while a pair waits in EMIT, then full rescan
        run_scan(4, fv, dr);
        run_scan(0, fv, dr);
        compare_pairs("t6");

        // Random contents (small value range gives runs and unsorted changes) with random ready
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 3));
            run_scan(1, fv, dr);
            compare_pairs($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
